ram_stream_reader: RTL and testbench

//  Read master for the single-port synchronous RAM (1-cycle registered read, read-first).
//  On a start pulse, reads LEN consecutive words from BASE_ADDR and emits them in order on a

---
 rtl/ram_stream_reader.sv | 126 ++++++++++++
 tb/tb_ram_stream_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streams LEN consecutive RAM words from BASE_ADDR onto a valid/ready port through a 2-entry buffer.
// Optional RAM_READER_CLEAR_EN: zero each location as it is read (clear-on-read).
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q, addr_q;
    logic [LEN_WIDTH-1:0]  len_q, issued_q;
    logic                  infl_q, infl_last_q;
    logic [1:0]            occ_q;
    logic [DATA_WIDTH-1:0] d0_q, d1_q;
    logic                  l0_q, l1_q;

    logic                  pop, issue;
    logic [2:0]            level;
    logic [ADDR_WIDTH-1:0] issue_addr;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = d0_q;
    assign m_last  = m_valid & l0_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == FIN);
    assign pop     = m_valid & m_ready;

    // Slots committed after this cycle; pop implies occ>=1 so no underflow.
    assign level      = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue      = !rst && (state_q == RUN) && (issued_q < len_q) && (level < 3'd2);
    assign issue_addr = base_q + ADDR_WIDTH'(issued_q);
    assign ram_addr   = issue ? issue_addr : addr_q;
    assign ram_wdata  = '0;

`ifdef RAM_READER_CLEAR_EN
    assign ram_we = issue;
`else
    assign ram_we = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= 2'd0;
            d0_q        <= '0;
            d1_q        <= '0;
            l0_q        <= 1'b0;
            l1_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    base_q   <= base_addr;
                    len_q    <= len;
                    issued_q <= '0;
                    state_q  <= (len == '0) ? FIN : RUN;
                end
                RUN:     if (pop && l0_q) state_q <= FIN;
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (issue) begin
                issued_q <= issued_q + LEN_WIDTH'(1);
                addr_q   <= issue_addr;
            end
            infl_q      <= issue;
            infl_last_q <= (issued_q == len_q - LEN_WIDTH'(1));

            // Read data arrives one cycle after issue and lands behind any buffered word.
            case ({infl_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        d0_q <= ram_rdata;
                        l0_q <= infl_last_q;
                    end else begin
                        d1_q <= ram_rdata;
                        l1_q <= infl_last_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    d0_q  <= d1_q;
                    l0_q  <= l1_q;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        d0_q <= ram_rdata;
                        l0_q <= infl_last_q;
                    end else begin
                        d0_q <= d1_q;
                        l0_q <= l1_q;
                        d1_q <= ram_rdata;
                        l1_q <= infl_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural read-first RAM, expected streams taken from RAM contents.
module tb_ram_stream_reader;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 13;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, ram_we, m_valid, m_ready, m_last;
    logic [AW-1:0] base_addr, ram_addr;
    logic [LW-1:0] len;
    logic [DW-1:0] ram_wdata, ram_rdata, m_data;

    logic [DW-1:0] mem [0:4095];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    // Single-port RAM, read-first; bd_* is a bench-only preload port.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic fill(input logic [AW-1:0] b, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bd_we   = 1'b1;
            bd_addr = b + AW'(i);
            bd_data = rnd ? ($urandom | 32'h1) : DW'(bd_addr);
        end
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // mode 0: always ready; 1: toggling ready plus a 5-cycle stall; 2: random ready and stray starts
    task automatic do_xfer(input string nm, input logic [AW-1:0] b, input int n, input int mode);
        logic [DW-1:0] exq[$];
        logic [DW-1:0] pd;
        logic          pv, pr, pl;
        logic [AW-1:0] k;
        int            got, cyc;
        for (int i = 0; i < n; i++) exq.push_back(mem[b + AW'(i)]);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = LW'(n); m_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); len = LW'($urandom);
        got = 0; cyc = 1; pv = 0; pr = 0; pl = 0; pd = '0;
        while (got < n && cyc < 300) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc >= 8 && cyc < 13) ? 1'b0 : 1'(cyc % 2);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            nvec++;
            if (busy !== 1'b1) begin
                nerr++; $display("FAIL %s busy cyc %0d got %b exp 1", nm, cyc, busy);
            end
            if (mode == 0) begin
                nvec++;
                if (m_valid !== (cyc >= 3)) begin
                    nerr++; $display("FAIL %s latency cyc %0d valid %b exp %b", nm, cyc, m_valid, cyc >= 3);
                end
            end
            if (pv && !pr) begin
                nvec++;
                if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
                    nerr++;
                    $display("FAIL %s hold cyc %0d got v%b %h l%b exp v1 %h l%b", nm, cyc, m_valid, m_data, m_last, pd, pl);
                end
            end
            k = ram_addr - b;
            nvec++;
            if (int'(k) > got + 2) begin
                nerr++; $display("FAIL %s ahead cyc %0d read idx %0d emitted %0d", nm, cyc, k, got);
            end
            if (m_valid && m_ready) begin
                nvec++;
                if (m_data !== exq[got] || m_last !== (got == n - 1)) begin
                    nerr++;
                    $display("FAIL %s word %0d got %h last %b exp %h last %b", nm, got, m_data, m_last, exq[got], got == n - 1);
                end
                got++;
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        nvec++;
        if (got != n) begin
            nerr++; $display("FAIL %s timeout words got %0d exp %0d", nm, got, n);
        end
        @(negedge clk);
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            nerr++; $display("FAIL %s done-pulse got d%b b%b v%b exp d1 b0 v0", nm, done, busy, m_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        nvec++;
        if (done !== 1'b0 || m_valid !== 1'b0) begin
            nerr++; $display("FAIL %s done-end got d%b v%b exp d0 v0", nm, done, m_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bd_we = 1'b0; m_ready = 1'b0;
        base_addr = '0; len = '0; bd_addr = '0; bd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
            nerr++; $display("FAIL reset flags got b%b d%b v%b l%b exp 0", busy, done, m_valid, m_last);
        end
        nvec++;
        if (m_data !== '0 || ram_addr !== '0 || ram_we !== 1'b0 || ram_wdata !== '0) begin
            nerr++; $display("FAIL reset data got %h addr %h we %b exp 0", m_data, ram_addr, ram_we);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_len0();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'h333; len = '0; m_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || ram_we !== 1'b0) begin
            nerr++; $display("FAIL len0 pulse got d%b b%b v%b we%b exp d1 b0 v0 we0", done, busy, m_valid, ram_we);
        end
        @(posedge clk); #1;
        @(negedge clk);
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0 || ram_we !== 1'b0) begin
            nerr++; $display("FAIL len0 after got d%b b%b v%b we%b exp 0", done, busy, m_valid, ram_we);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic bad;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'h040; len = LW'(10); m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (m_valid !== 1'b1 || m_data !== mem[12'h043]) begin
            nerr++; $display("FAIL rstmid word3 got v%b %h exp v1 %h", m_valid, m_data, mem[12'h043]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== '0) begin
            nerr++; $display("FAIL rstmid state got v%b b%b d%b addr %h exp 0", m_valid, busy, done, ram_addr);
        end
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done !== 1'b0 || m_valid !== 1'b0) bad = 1'b1;
        end
        nvec++;
        if (bad) begin
            nerr++; $display("FAIL rstmid quiet got activity exp none");
        end
        @(posedge clk); #1;
        do_xfer("restart", 12'h100, 2, 0);
    endtask

    task automatic test_clear();
        logic [DW-1:0] orig [3];
        fill(12'h020, 3, 1'b1);
        for (int i = 0; i < 3; i++) orig[i] = mem[12'h020 + AW'(i)];
        do_xfer("clear", 12'h020, 3, 0);
        for (int i = 0; i < 3; i++) begin
            nvec++;
`ifdef RAM_READER_CLEAR_EN
            if (mem[12'h020 + AW'(i)] !== '0) begin
                nerr++; $display("FAIL clear mem[%0d] got %h exp 0", i, mem[12'h020 + AW'(i)]);
            end
`else
            if (mem[12'h020 + AW'(i)] !== orig[i]) begin
                nerr++; $display("FAIL keep mem[%0d] got %h exp %h", i, mem[12'h020 + AW'(i)], orig[i]);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        int n;
        repeat (6) begin
            b = AW'($urandom);
            n = $urandom_range(1, 20);
            fill(b, n, 1'b1);
            do_xfer("rand", b, n, 2);
        end
    endtask

    initial begin
        test_reset();
        fill(12'h010, 4, 1'b0);
        fill(12'hFFE, 4, 1'b0);
        fill(12'h080, 8, 1'b1);
        fill(12'h040, 16, 1'b0);
        fill(12'h100, 2, 1'b0);
        do_xfer("basic", 12'h010, 4, 0);
        do_xfer("wrap", 12'hFFE, 4, 0);
        do_xfer("backpressure", 12'h080, 8, 1);
        test_len0();
        test_reset_mid();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
